// File: rtl/sif_wa_store.sv
// rtl/sif_wa_store.sv - posted-write FIFO draining into a register bank, with reads ordered behind older pending writes
module sif_wa_store #(
    parameter int DEPTH  = 4,
    parameter int REG_AW = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wa_wr_s,
    input  logic [15:0]                wa_addr,
    input  logic [15:0]                wa_data_wr,
    input  logic                       drain_en,
    input  logic                       rd_req,
    input  logic [15:0]                rd_addr,
    output logic [15:0]                rd_data,
    output logic                       rd_valid,
    output logic                       rd_busy,
    output logic                       wa_full,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       wr_drop,
    output logic                       addr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = 1 << REG_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READ
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [REG_AW-1:0]   fifo_addr [DEPTH];
    logic [15:0]         fifo_data [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count_nxt;
    logic [CW-1:0]       wait_cnt;
    logic [CW-1:0]       wait_cnt_nxt;
    logic [15:0]         bank [NW];
    logic [REG_AW-1:0]   rd_addr_q;
    logic [REG_AW-1:0]   rd_addr_nxt;

    logic                in_range;
    logic                push;
    logic                pop;
    logic                fifo_hit;
    logic                hazard;
    logic                unused_rd_addr_hi;

    // Only the bank-index bits of a read address are meaningful.
    assign unused_rd_addr_hi = ^rd_addr[15:REG_AW];

    assign in_range = (wa_addr[15:REG_AW] == '0);
    // A full FIFO drops the write even if a pop frees a slot at the same edge.
    assign push     = wa_wr_s && in_range && !wa_full;
    assign pop      = (fill_level != '0) && drain_en && (state != S_READ);
    assign rd_busy  = (state != S_IDLE);

    always_comb begin
        count_nxt = fill_level;
        case ({push, pop})
            2'b10:   count_nxt = fill_level + CW'(1);
            2'b01:   count_nxt = fill_level - CW'(1);
            default: count_nxt = fill_level;
        endcase
    end

    // Scan the live FIFO slots, oldest first, for a write to the requested word.
    always_comb begin
        fifo_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < fill_level) &&
                (fifo_addr[rd_ptr + PW'(k)] == rd_addr[REG_AW-1:0])) begin
                fifo_hit = 1'b1;
            end
        end
    end

    assign hazard = fifo_hit || (push && (wa_addr[REG_AW-1:0] == rd_addr[REG_AW-1:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            wa_full    <= 1'b0;
            wr_drop    <= 1'b0;
            addr_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
            for (int i = 0; i < NW; i++) begin
                bank[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= wa_addr[REG_AW-1:0];
                fifo_data[wr_ptr] <= wa_data_wr;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                bank[fifo_addr[rd_ptr]] <= fifo_data[rd_ptr];
                rd_ptr                  <= rd_ptr + PW'(1);
            end
            fill_level <= count_nxt;
            wa_full    <= (count_nxt == CW'(DEPTH));
            wr_drop    <= wa_wr_s && in_range && wa_full;
            addr_err   <= wa_wr_s && !in_range;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        rd_addr_nxt  = rd_addr_q;
        case (state)
            S_IDLE: begin
                if (rd_req) begin
                    rd_addr_nxt = rd_addr[REG_AW-1:0];
                    if (hazard) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = count_nxt;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_WAIT: begin
                // wait_cnt counts only entries older than the read; later pushes never add to it.
                if (wait_cnt == '0) begin
                    state_nxt = S_READ;
                end else if (pop) begin
                    wait_cnt_nxt = wait_cnt - CW'(1);
                    if (wait_cnt == CW'(1)) begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            rd_addr_q <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            rd_addr_q <= rd_addr_nxt;
            rd_valid  <= (state == S_READ);
            if (state == S_READ) begin
                rd_data <= bank[rd_addr_q];
            end
        end
    end

endmodule

// File: tb/tb_sif_wa_store.sv
// tb/tb_sif_wa_store.sv - directed and randomized checks of sif_wa_store against a queue-based model
module tb_sif_wa_store;

    localparam int DEPTH  = 4;
    localparam int REG_AW = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wa_wr_s = 1'b0;
    logic [15:0]   wa_addr = '0;
    logic [15:0]   wa_data_wr = '0;
    logic          drain_en = 1'b0;
    logic          rd_req = 1'b0;
    logic [15:0]   rd_addr = '0;
    logic [15:0]   rd_data;
    logic          rd_valid;
    logic          rd_busy;
    logic          wa_full;
    logic [CW-1:0] fill_level;
    logic          wr_drop;
    logic          addr_err;

    int errors = 0;
    int checks = 0;

    sif_wa_store #(.DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wa_wr_s    (wa_wr_s),
        .wa_addr    (wa_addr),
        .wa_data_wr (wa_data_wr),
        .drain_en   (drain_en),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_busy    (rd_busy),
        .wa_full    (wa_full),
        .fill_level (fill_level),
        .wr_drop    (wr_drop),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending writes as a sequence-tagged queue, reads resolved to a value when accepted.
    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
        int unsigned seq;
    } ent_t;

    ent_t          mq[$];
    logic [15:0]   mbank [16];
    int unsigned   mseq;
    bit            m_wait_older;
    bit            m_issue;
    int unsigned   m_read_seq;
    logic [15:0]   m_read_val;
    logic [15:0]   e_data;
    bit            e_valid, e_drop, e_aerr;

    bit            full_b, inr, do_push, do_pop, accept, hz, older_left;
    logic [3:0]    ra;
    logic [15:0]   val;
    ent_t          e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            foreach (mbank[i]) mbank[i] = '0;
            mseq = 0;
            m_wait_older = 0;
            m_issue = 0;
            e_valid = 0;
            e_data = '0;
            e_drop = 0;
            e_aerr = 0;
        end else begin
            full_b  = (mq.size() == DEPTH);
            inr     = (wa_addr < 16'(1 << REG_AW));
            do_push = wa_wr_s && inr && !full_b;
            do_pop  = (mq.size() > 0) && drain_en && !m_issue;
            accept  = rd_req && !(m_wait_older || m_issue);
            hz = 0;
            ra = rd_addr[3:0];
            val = mbank[ra];
            if (accept) begin
                foreach (mq[i]) if (mq[i].a == ra) begin val = mq[i].d; hz = 1; end
                if (do_push && wa_addr[3:0] == ra) begin val = wa_data_wr; hz = 1; end
            end
            e_valid = m_issue;
            if (m_issue) e_data = m_read_val;
            e_drop = wa_wr_s && inr && full_b;
            e_aerr = wa_wr_s && !inr;
            if (do_pop) begin
                e = mq.pop_front();
                mbank[e.a] = e.d;
            end
            if (do_push) begin
                mseq++;
                mq.push_back('{a: wa_addr[3:0], d: wa_data_wr, seq: mseq});
            end
            if (m_issue) begin
                m_issue = 0;
            end else if (m_wait_older) begin
                older_left = 0;
                foreach (mq[i]) if (mq[i].seq <= m_read_seq) older_left = 1;
                if (!older_left) begin
                    m_wait_older = 0;
                    m_issue = 1;
                end
            end else if (accept) begin
                m_read_val = val;
                if (hz) begin
                    m_wait_older = 1;
                    m_read_seq = mseq;
                end else begin
                    m_issue = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #3;
        chk("rd_valid", rd_valid, e_valid);
        chk("rd_data", rd_data, e_data);
        chk("rd_busy", rd_busy, m_wait_older || m_issue);
        chk("fill_level", fill_level, mq.size());
        chk("wa_full", wa_full, mq.size() == DEPTH);
        chk("wr_drop", wr_drop, e_drop);
        chk("addr_err", addr_err, e_aerr);
    end

    task automatic cyc(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic r, input logic [15:0] rad);
        wa_wr_s = w;
        wa_addr = a;
        wa_data_wr = d;
        rd_req = r;
        rd_addr = rad;
        @(negedge clk);
        wa_wr_s = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!rd_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!rd_valid) chk("read_timeout", 0, 1);
    endtask

    task automatic do_read(input logic [15:0] a, output logic [15:0] d, output int lat);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, a);
        wait_valid(lat);
        d = rd_data;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    logic [15:0] d;
    int          lat;
    int          vcount;

    initial begin
        idle(3);
        chk("reset_outputs", {rd_data, rd_valid, rd_busy, wa_full, fill_level, wr_drop, addr_err}, 0);
        rst_n = 1'b1;

        // 1: read of an untouched word
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0003);
        chk("t1_busy", rd_busy, 1);
        @(negedge clk);
        chk("t1_valid", rd_valid, 1);
        chk("t1_data", rd_data, 16'h0000);
        chk("t1_busy_done", rd_busy, 0);

        // 2: write drains, then plain read
        drain_en = 1'b1;
        cyc(1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0);
        chk("t2_fill1", fill_level, 1);
        idle(2);
        chk("t2_fill0", fill_level, 0);
        do_read(16'h0005, d, lat);
        chk("t2_data", d, 16'hBEEF);
        chk("t2_latency", lat, 2);

        // 3: fill, overflow, drain
        drain_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'(i), 16'h3000 + 16'(i), 1'b0, 16'h0);
            if (i == 3) begin
                chk("t3_full", wa_full, 1);
                chk("t3_fill4", fill_level, 4);
            end
        end
        chk("t3_drop", wr_drop, 1);
        drain_en = 1'b1;
        idle(4);
        chk("t3_drained", fill_level, 0);
        do_read(16'h0004, d, lat);
        chk("t3_dropped_word", d, 16'h0000);

        // 4: read waits only on the older write
        drain_en = 1'b0;
        cyc(1'b1, 16'h0002, 16'h1234, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0002);
        cyc(1'b1, 16'h0002, 16'h5678, 1'b0, 16'h0);
        idle(3);
        chk("t4_wait_busy", rd_busy, 1);
        chk("t4_no_valid", rd_valid, 0);
        drain_en = 1'b1;
        wait_valid(lat);
        chk("t4_old_data", rd_data, 16'h1234);
        do_read(16'h0002, d, lat);
        chk("t4_new_data", d, 16'h5678);

        // 5: out-of-range write
        pulse_reset();
        cyc(1'b1, 16'h0100, 16'hAAAA, 1'b0, 16'h0);
        chk("t5_addr_err", addr_err, 1);
        chk("t5_fill", fill_level, 0);
        idle(1);
        do_read(16'h0000, d, lat);
        chk("t5_data", d, 16'h0000);

        // 6: reset while a read waits
        drain_en = 1'b0;
        cyc(1'b1, 16'h0007, 16'h1111, 1'b0, 16'h0);
        cyc(1'b1, 16'h0008, 16'h2222, 1'b0, 16'h0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0008);
        idle(2);
        chk("t6_busy", rd_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {rd_data, rd_valid, rd_busy, wa_full, fill_level, wr_drop, addr_err}, 0);
        idle(2);
        rst_n = 1'b1;
        drain_en = 1'b1;
        vcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (rd_valid) vcount++;
        end
        chk("t6_no_stale_valid", vcount, 0);
        do_read(16'h0008, d, lat);
        chk("t6_bank8", d, 16'h0000);
        do_read(16'h0007, d, lat);
        chk("t6_bank7", d, 16'h0000);

        // Randomized traffic, concentrated on a few addresses to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            if (c % 16 == 0) drain_en = ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                rst_n = 1'b0;
            end else if (c == 1503) begin
                rst_n = 1'b1;
            end
            wa_wr_s    = ($urandom_range(0, 1) == 1);
            wa_addr    = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16, 65535))
                                                     : 16'($urandom_range(0, 3));
            wa_data_wr = 16'($urandom);
            rd_req     = ($urandom_range(0, 2) == 0);
            rd_addr    = {12'($urandom), 4'($urandom_range(0, 3))};
            @(negedge clk);
        end
        wa_wr_s = 1'b0;
        rd_req = 1'b0;
        drain_en = 1'b1;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sif_wa_store.md
Name: sif_wa_store

Overview:
- Downstream consumer of the SIF write-side (wa_*) stream.
- Posts each incoming write into a small FIFO and drains it into a local register bank of 2^REG_AW 16-bit words.
- Serves reads of the bank, with ordering protection against writes still pending in the FIFO.
- This is the storage the SIF bridge writes into and the source of read data returned on the X side.

Parameters:
DEPTH, 4, posted-write FIFO entries; power of two, at least 2
REG_AW, 4, register-bank address width; bank holds 2^REG_AW words

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wa_wr_s  in  1  write strobe, one write per cycle
wa_addr  in  16  write address
wa_data_wr  in  16  write data
drain_en  in  1  permits FIFO-to-bank transfers
rd_req  in  1  read request, accepted only when rd_busy=0
rd_addr  in  16  read address, sampled with rd_req
rd_data  out  16  read result
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_busy  out  1  read in progress; new rd_req ignored
wa_full  out  1  FIFO count == DEPTH (registered)
fill_level  out  $clog2(DEPTH+1)  FIFO occupancy
wr_drop  out  1  one-cycle pulse, write lost to overflow
addr_err  out  1  one-cycle pulse, write address out of range

Behaviour:
- Reset (async, rst_n=0): FIFO empty; all bank words 0x0000; read FSM in IDLE; every output 0.
  - Pending writes and any in-flight read are discarded; no rd_valid is produced for an aborted read.
- Write acceptance:
  - If wa_wr_s=1 and wa_addr[15:REG_AW]!=0: nothing pushed; addr_err=1 in the next cycle.
  - If wa_wr_s=1, address in range, and wa_full=1: nothing pushed; wr_drop=1 in the next cycle.
    - This holds even when a pop occurs in the same cycle.
  - Otherwise the {addr[REG_AW-1:0], data} entry is pushed at the edge.
- Drain: at an edge where the FIFO is non-empty, drain_en=1 and the FSM is not in READ:
  - the head entry is written to the bank and popped;
  - at most one pop per cycle.
- FIFO pointers wrap modulo DEPTH.
  - Simultaneous push and pop leave fill_level unchanged.
  - fill_level and wa_full update at the same edge as the push or pop.
- Read FSM states: IDLE, WAIT, READ.
  - IDLE: at an edge with rd_req=1, latch rd_addr[REG_AW-1:0]. rd_addr upper bits are ignored.
    - If any FIFO entry present, or pushed at the same edge, matches the address: go to WAIT. Set wait_cnt = fill_level after that edge.
    - Otherwise go to READ.
  - WAIT: wait_cnt decrements on each pop. Go to READ at the edge where wait_cnt reaches 0.
    - Only entries older than the read are waited on. Writes arriving during WAIT are newer and do not extend the wait.
  - READ: drain is suppressed for this cycle. At the next edge: rd_data <= bank[addr], rd_valid <= 1, go to IDLE.
- rd_busy=1 in WAIT and READ.
- Latency without a hazard:
  - rd_req sampled at edge k;
  - rd_valid high in the cycle after edge k+1;
  - next request can be accepted at edge k+2.
- rd_data holds its value until the next rd_valid.
- With drain_en held 0, WAIT persists indefinitely; this is legal.
- Result ordering: a read returns the newest value written before the request was accepted, never a later one.

Test Plan:
1. Reset, then rd_req addr 0x0003 -> rd_busy=1 for one cycle; rd_valid=1 with rd_data=0x0000 two cycles after request.
2. Write 0x0005/0xBEEF with drain_en=1, idle 2 cycles, read 0x0005 -> rd_data=0xBEEF, no WAIT; fill_level back to 0.
3. drain_en=0, five back-to-back writes to 0x0000..0x0004 -> after the 4th, wa_full=1 and fill_level=4. 5th write gives wr_drop pulse. drain_en=1 -> four pops over 4 cycles. Read 0x0004 -> 0x0000.
4. drain_en=0, write 0x0002/0x1234, then read 0x0002 -> rd_busy held 1 (WAIT). Write 0x0002/0x5678 during WAIT, then drain_en=1 -> rd_data=0x1234, not 0x5678; a later read gives 0x5678.
5. Write 0x0100/0xAAAA -> addr_err pulse; fill_level unchanged; read 0x0000 gives 0x0000.
6. drain_en=0, two writes, read of a matching address (WAIT), assert rst_n=0 mid-wait -> all outputs 0, fill_level=0, no rd_valid after release, bank reads 0x0000.
